// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: checks prediction vs outcome, pulses predictor updates,
// and runs a redirect/squash recovery FSM. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN            = 32,
  parameter int PHT_ADDRESS     = 9,
  parameter int GHR_SIZE        = 9,
  parameter int RAS_ADDRESS     = 3,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [XLEN-1:0]        res_pc,
  input  logic [XLEN-1:0]        res_pred_target,
  input  logic [XLEN-1:0]        res_actual_target,
  input  logic                   res_is_branch,
  input  logic                   res_is_jump,
  input  logic                   res_is_call,
  input  logic                   res_is_ret,
  input  logic                   res_pred_taken,
  input  logic                   res_actual_taken,
  input  logic [GHR_SIZE-1:0]    res_ghr_snap,
  input  logic [PHT_ADDRESS-1:0] res_pht_index,
  input  logic [RAS_ADDRESS-1:0] res_sp_snap,
  input  logic [2*XLEN-1:0]      res_ras_snap,
  output logic                   actual_taken,
  output logic                   mispredict,
  output logic                   restore_ghr,
  output logic                   restore_ras,
  output logic                   update_pht,
  output logic                   update_btb,
  output logic                   update_ras,
  output logic                   ex_is_ret,
  output logic                   ex_is_branch,
  output logic [XLEN-1:0]        actual_target_address,
  output logic [XLEN-1:0]        actual_return_address,
  output logic [XLEN-1:0]        ex_pc,
  output logic [GHR_SIZE-1:0]    ghr_snap,
  output logic [PHT_ADDRESS-1:0] rb_pht_index,
  output logic [RAS_ADDRESS-1:0] rb_sp_snap,
  output logic [2*XLEN-1:0]      rb_ras_snap,
  output logic                   redirect_valid,
  input  logic                   redirect_ready,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   flush
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]            perf_branches,
  output logic [31:0]            perf_mispredicts
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_SQUASH} state_t;

  localparam logic [3:0] LP_RC = 4'(RECOVERY_CYCLES);

  state_t                 r_state;
  logic [3:0]             r_count;
  logic                   r_actual_taken, r_mispredict, r_restore_ghr, r_restore_ras;
  logic                   r_update_pht, r_update_btb, r_update_ras, r_ex_is_ret, r_ex_is_branch;
  logic [XLEN-1:0]        r_target, r_return, r_ex_pc, r_redirect_pc;
  logic [GHR_SIZE-1:0]    r_ghr_snap;
  logic [PHT_ADDRESS-1:0] r_pht_index;
  logic [RAS_ADDRESS-1:0] r_sp_snap;
  logic [2*XLEN-1:0]      r_ras_snap;

  logic                   w_taken, w_tgt_miss, w_misp, w_accept;
  logic [XLEN-1:0]        w_pc4;

  // Jumps and returns are always taken regardless of the resolved direction bit.
  assign w_taken    = (res_is_jump | res_is_ret) ? 1'b1 : res_actual_taken;
  assign w_tgt_miss = res_pred_target != res_actual_target;
  assign w_misp     = (res_pred_taken != w_taken) | (w_taken & w_tgt_miss);
  assign w_accept   = res_valid & (r_state == S_IDLE);
  assign w_pc4      = res_pc + XLEN'(4);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_actual_taken <= 1'b0;
      r_mispredict   <= 1'b0;
      r_restore_ghr  <= 1'b0;
      r_restore_ras  <= 1'b0;
      r_update_pht   <= 1'b0;
      r_update_btb   <= 1'b0;
      r_update_ras   <= 1'b0;
      r_ex_is_ret    <= 1'b0;
      r_ex_is_branch <= 1'b0;
      r_target       <= '0;
      r_return       <= '0;
      r_ex_pc        <= '0;
      r_redirect_pc  <= '0;
      r_ghr_snap     <= '0;
      r_pht_index    <= '0;
      r_sp_snap      <= '0;
      r_ras_snap     <= '0;
    end else begin
      r_actual_taken <= 1'b0;
      r_mispredict   <= 1'b0;
      r_restore_ghr  <= 1'b0;
      r_restore_ras  <= 1'b0;
      r_update_pht   <= 1'b0;
      r_update_btb   <= 1'b0;
      r_update_ras   <= 1'b0;
      r_ex_is_ret    <= 1'b0;
      r_ex_is_branch <= 1'b0;
      if (w_accept) begin
        r_actual_taken <= w_taken;
        r_mispredict   <= w_misp;
        r_restore_ghr  <= w_misp;
        r_restore_ras  <= w_misp;
        r_update_pht   <= res_is_branch;
        r_update_btb   <= w_taken & (~res_pred_taken | w_tgt_miss);
        r_update_ras   <= res_is_call;
        r_ex_is_ret    <= res_is_ret;
        r_ex_is_branch <= res_is_branch;
        r_target       <= res_actual_target;
        r_return       <= w_pc4;
        r_ex_pc        <= res_pc;
        r_ghr_snap     <= res_ghr_snap;
        r_pht_index    <= res_pht_index;
        r_sp_snap      <= res_sp_snap;
        r_ras_snap     <= res_ras_snap;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_misp) begin
            r_state       <= S_REDIRECT;
            r_redirect_pc <= w_taken ? res_actual_target : w_pc4;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            r_state <= S_SQUASH;
            r_count <= LP_RC;
          end
        end
        S_SQUASH: begin
          // SQUASH lasts RECOVERY_CYCLES cycles; the last decrement returns to IDLE.
          if (r_count <= 4'd1) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so the port reads 0 while reset is held.
  assign res_ready             = reset & (r_state != S_REDIRECT);
  assign redirect_valid        = r_state == S_REDIRECT;
  assign flush                 = r_state != S_IDLE;
  assign redirect_pc           = r_redirect_pc;
  assign actual_taken          = r_actual_taken;
  assign mispredict            = r_mispredict;
  assign restore_ghr           = r_restore_ghr;
  assign restore_ras           = r_restore_ras;
  assign update_pht            = r_update_pht;
  assign update_btb            = r_update_btb;
  assign update_ras            = r_update_ras;
  assign ex_is_ret             = r_ex_is_ret;
  assign ex_is_branch          = r_ex_is_branch;
  assign actual_target_address = r_target;
  assign actual_return_address = r_return;
  assign ex_pc                 = r_ex_pc;
  assign ghr_snap              = r_ghr_snap;
  assign rb_pht_index          = r_pht_index;
  assign rb_sp_snap            = r_sp_snap;
  assign rb_ras_snap           = r_ras_snap;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_perf_br, r_perf_mp;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_perf_br <= '0;
      r_perf_mp <= '0;
    end else if (w_accept) begin
      if (r_perf_br != 32'hFFFF_FFFF)           r_perf_br <= r_perf_br + 32'd1;
      if (w_misp && r_perf_mp != 32'hFFFF_FFFF) r_perf_mp <= r_perf_mp + 32'd1;
    end
  end

  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mp;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed test-plan cases plus randomized
// traffic against a transaction-level reference model.
module tb_branch_resolve_unit;
  localparam int XLEN = 32, PHT = 9, GHR = 9, RAS = 3, RC = 2;

  logic CLK = 1'b0, reset = 1'b0;
  logic res_valid = 1'b0, res_ready;
  logic [XLEN-1:0] res_pc = '0, res_pred_target = '0, res_actual_target = '0;
  logic res_is_branch = 1'b0, res_is_jump = 1'b0, res_is_call = 1'b0, res_is_ret = 1'b0;
  logic res_pred_taken = 1'b0, res_actual_taken = 1'b0;
  logic [GHR-1:0] res_ghr_snap = '0;
  logic [PHT-1:0] res_pht_index = '0;
  logic [RAS-1:0] res_sp_snap = '0;
  logic [2*XLEN-1:0] res_ras_snap = '0;
  logic actual_taken, mispredict, restore_ghr, restore_ras, update_pht, update_btb, update_ras;
  logic ex_is_ret, ex_is_branch, redirect_valid, redirect_ready = 1'b0, flush;
  logic [XLEN-1:0] actual_target_address, actual_return_address, ex_pc, redirect_pc;
  logic [GHR-1:0] ghr_snap;
  logic [PHT-1:0] rb_pht_index;
  logic [RAS-1:0] rb_sp_snap;
  logic [2*XLEN-1:0] rb_ras_snap;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  branch_resolve_unit #(.XLEN(XLEN), .PHT_ADDRESS(PHT), .GHR_SIZE(GHR), .RAS_ADDRESS(RAS),
                        .RECOVERY_CYCLES(RC)) dut (
    .CLK(CLK), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_pred_target(res_pred_target), .res_actual_target(res_actual_target),
    .res_is_branch(res_is_branch), .res_is_jump(res_is_jump), .res_is_call(res_is_call),
    .res_is_ret(res_is_ret), .res_pred_taken(res_pred_taken), .res_actual_taken(res_actual_taken),
    .res_ghr_snap(res_ghr_snap), .res_pht_index(res_pht_index), .res_sp_snap(res_sp_snap),
    .res_ras_snap(res_ras_snap), .actual_taken(actual_taken), .mispredict(mispredict),
    .restore_ghr(restore_ghr), .restore_ras(restore_ras), .update_pht(update_pht),
    .update_btb(update_btb), .update_ras(update_ras), .ex_is_ret(ex_is_ret),
    .ex_is_branch(ex_is_branch), .actual_target_address(actual_target_address),
    .actual_return_address(actual_return_address), .ex_pc(ex_pc), .ghr_snap(ghr_snap),
    .rb_pht_index(rb_pht_index), .rb_sp_snap(rb_sp_snap), .rb_ras_snap(rb_ras_snap),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush(flush)
`ifdef BRU_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  wire [8:0] w_pulse = {actual_taken, mispredict, restore_ghr, restore_ras, update_pht,
                        update_btb, update_ras, ex_is_ret, ex_is_branch};
  wire [3*XLEN-1:0] w_addr = {actual_target_address, actual_return_address, ex_pc};
  wire [GHR+PHT+RAS+2*XLEN-1:0] w_snap = {ghr_snap, rb_pht_index, rb_sp_snap, rb_ras_snap};
  wire [2:0] w_hs = {res_ready, redirect_valid, flush};
`ifdef BRU_PERF_CNT_EN
  wire [63:0] w_perf = {perf_branches, perf_mispredicts};
`else
  wire [63:0] w_perf = '0;
`endif

  int vecs = 0, errs = 0;

  // Reference model: pending-redirect flag plus remaining squash cycles.
  bit m_redir;
  int m_sq;
  logic [8:0] e_pulse;
  logic [3*XLEN-1:0] e_addr;
  logic [GHR+PHT+RAS+2*XLEN-1:0] e_snap;
  logic [XLEN-1:0] e_rpc;
  logic [31:0] e_pbr, e_pmp;

  task automatic model_reset();
    m_redir = 0; m_sq = 0; e_pulse = '0; e_addr = '0; e_snap = '0; e_rpc = '0;
    e_pbr = '0; e_pmp = '0;
  endtask

  task automatic model_step();
    bit tk, mp;
    logic [XLEN-1:0] p4;
    e_pulse = '0;
    if (!m_redir && m_sq == 0) begin
      if (res_valid) begin
        tk = (res_is_jump || res_is_ret) ? 1'b1 : res_actual_taken;
        mp = (res_pred_taken != tk) || (tk && res_pred_target != res_actual_target);
        p4 = res_pc + 32'd4;
        e_pulse = {tk, mp, mp, mp, res_is_branch,
                   tk && (!res_pred_taken || res_pred_target != res_actual_target),
                   res_is_call, res_is_ret, res_is_branch};
        e_addr = {res_actual_target, p4, res_pc};
        e_snap = {res_ghr_snap, res_pht_index, res_sp_snap, res_ras_snap};
        if (e_pbr != 32'hFFFF_FFFF) e_pbr = e_pbr + 1;
        if (mp && e_pmp != 32'hFFFF_FFFF) e_pmp = e_pmp + 1;
        if (mp) begin m_redir = 1; e_rpc = tk ? res_actual_target : p4; end
      end
    end else if (m_redir) begin
      if (redirect_ready) begin m_redir = 0; m_sq = RC; end
    end else begin
      m_sq = m_sq - 1;
    end
  endtask

  function automatic logic [63:0] exp_perf();
`ifdef BRU_PERF_CNT_EN
    return {e_pbr, e_pmp};
`else
    return 64'd0;
`endif
  endfunction

  task automatic put(bit v, logic [31:0] pc, pt, at, bit br, jp, cl, rt, ptk, atk);
    res_valid = v; res_pc = pc; res_pred_target = pt; res_actual_target = at;
    res_is_branch = br; res_is_jump = jp; res_is_call = cl; res_is_ret = rt;
    res_pred_taken = ptk; res_actual_taken = atk;
    res_ghr_snap = GHR'($urandom); res_pht_index = PHT'($urandom);
    res_sp_snap = RAS'($urandom); res_ras_snap = {$urandom, $urandom};
  endtask

  // Inputs are already driven (after a negedge); advance one edge and sample #1 later.
  task automatic tick();
    model_step();
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    @(negedge CLK);
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    redirect_ready = 1'b1;
    for (int i = 0; i < 10 && (m_redir || m_sq != 0); i++) begin tick(); @(negedge CLK); end
    vecs++;
    if (flush !== 1'b0) begin errs++; $display("FAIL drain_idle flush=%b want 0", flush); end
  endtask

  task automatic test_reset();
    reset = 1'b0; model_reset(); #2;
    vecs++;
    if ({w_pulse, w_addr, w_snap, w_hs, redirect_pc, w_perf} !== '0) begin
      errs++; $display("FAIL reset_outputs got nonzero outputs want all 0");
    end
    @(negedge CLK); reset = 1'b1; #1;
    vecs++;
    if (w_hs !== 3'b100) begin errs++; $display("FAIL reset_idle hs=%b want 100", w_hs); end
  endtask

  task automatic test_jal();
    @(negedge CLK);
    put(1, 32'h4, 32'h0, 32'h4, 0, 1, 0, 0, 0, 0);
    redirect_ready = 1'b0;
    tick();
    vecs++;
    if ({mispredict, update_btb, ex_is_branch, redirect_valid} !== 4'b1101) begin
      errs++; $display("FAIL jal_pulses got %b want 1101", {mispredict, update_btb, ex_is_branch, redirect_valid});
    end
    vecs++;
    if (actual_return_address !== 32'h8 || redirect_pc !== 32'h4) begin
      errs++; $display("FAIL jal_addr ret=%h rpc=%h want 8/4", actual_return_address, redirect_pc);
    end
    drain();
  endtask

  task automatic test_branch_hit();
    @(negedge CLK);
    put(1, 32'h8, 32'h100, 32'h100, 1, 0, 0, 0, 1, 1);
    tick();
    vecs++;
    if ({update_pht, actual_taken, mispredict, redirect_valid, flush} !== 5'b11000) begin
      errs++; $display("FAIL branch_hit got %b want 11000", {update_pht, actual_taken, mispredict, redirect_valid, flush});
    end
    @(negedge CLK); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    vecs++;
    if ({w_pulse, redirect_valid, flush} !== '0) begin
      errs++; $display("FAIL branch_hit_oneshot pulses=%b rv=%b fl=%b want 0", w_pulse, redirect_valid, flush);
    end
  endtask

  task automatic test_branch_mispredict_snap();
    @(negedge CLK);
    put(1, 32'h10, 32'h200, 32'h200, 1, 0, 0, 0, 1, 0);
    res_pht_index = 9'h0A1; res_ghr_snap = 9'h155;
    redirect_ready = 1'b0;
    tick();
    vecs++;
    if ({mispredict, restore_ghr, update_btb} !== 3'b110 || redirect_pc !== 32'h14) begin
      errs++; $display("FAIL br_misp got %b rpc=%h want 110 rpc=14", {mispredict, restore_ghr, update_btb}, redirect_pc);
    end
    vecs++;
    if (rb_pht_index !== 9'h0A1 || ghr_snap !== 9'h155) begin
      errs++; $display("FAIL br_snap pht=%h ghr=%h want 0a1/155", rb_pht_index, ghr_snap);
    end
    drain();
  endtask

  task automatic test_redirect_stall();
    logic [31:0] rpc;
    @(negedge CLK);
    put(1, 32'h40, 32'h80, 32'h90, 0, 1, 0, 0, 1, 1);
    redirect_ready = 1'b0;
    tick();
    rpc = redirect_pc;
    vecs++;
    if (rpc !== 32'h90) begin errs++; $display("FAIL stall_rpc got %h want 90", rpc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      put(1, 32'h50, 32'h0, 32'h60, 0, 1, 0, 0, 0, 0);
      vecs++;
      if (res_ready !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== rpc) begin
        errs++; $display("FAIL stall_hold rdy=%b rv=%b rpc=%h want 0/1/%h", res_ready, redirect_valid, redirect_pc, rpc);
      end
      tick();
      vecs++;
      if (w_pulse !== '0) begin errs++; $display("FAIL stall_pulse got %b want 0", w_pulse); end
    end
    @(negedge CLK); redirect_ready = 1'b1; tick();
    redirect_ready = 1'b0;
    for (int i = 0; i < RC; i++) begin
      @(negedge CLK);
      put(1, 32'h70, 32'h0, 32'h74, 0, 1, 1, 0, 0, 0);
      vecs++;
      if (res_ready !== 1'b1 || flush !== 1'b1) begin
        errs++; $display("FAIL squash_ready rdy=%b flush=%b want 1/1", res_ready, flush);
      end
      tick();
      vecs++;
      if (w_pulse !== '0) begin errs++; $display("FAIL squash_pulse got %b want 0", w_pulse); end
    end
    vecs++;
    if (flush !== 1'b0) begin errs++; $display("FAIL squash_exit flush=%b want 0", flush); end
    @(negedge CLK); put(1, 32'h80, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0); tick();
    vecs++;
    if ({update_pht, mispredict} !== 2'b10 || ex_pc !== 32'h80) begin
      errs++; $display("FAIL post_squash upd=%b pc=%h want 10/80", {update_pht, mispredict}, ex_pc);
    end
  endtask

  task automatic test_call_wrap();
    @(negedge CLK);
    put(1, 32'hFFFF_FFFC, 32'h1000, 32'h1000, 0, 1, 1, 0, 1, 0);
    tick();
    vecs++;
    if (update_ras !== 1'b1 || actual_return_address !== 32'h0) begin
      errs++; $display("FAIL call_wrap ras=%b ret=%h want 1/0", update_ras, actual_return_address);
    end
  endtask

  task automatic test_reset_in_redirect();
    @(negedge CLK);
    put(1, 32'h20, 32'h0, 32'h30, 0, 1, 0, 1, 0, 0);
    redirect_ready = 1'b0;
    tick();
    vecs++;
    if (redirect_valid !== 1'b1) begin errs++; $display("FAIL rst_setup rv=%b want 1", redirect_valid); end
    #1 reset = 1'b0; model_reset(); #1;
    vecs++;
    if ({w_pulse, w_addr, w_snap, w_hs, redirect_pc, w_perf} !== '0) begin
      errs++; $display("FAIL reset_in_redirect outputs nonzero want all 0");
    end
    @(negedge CLK); reset = 1'b1; put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vecs++;
    if (w_hs !== 3'b100) begin errs++; $display("FAIL rst_no_redirect hs=%b want 100", w_hs); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      put(1, 32'h200 + 32'(i*4), 32'h300, 32'h300, 1, 0, 0, 0, 1, 1);
      tick();
      vecs++;
      if (w_pulse !== e_pulse || w_addr !== e_addr) begin
        errs++; $display("FAIL b2b pulse=%b want %b pc=%h", w_pulse, e_pulse, ex_pc);
      end
    end
  endtask

  task automatic test_random();
    int k;
    logic [31:0] at;
    for (int n = 0; n < 600; n++) begin
      @(negedge CLK);
      k = $urandom_range(0, 3);
      at = 32'($urandom_range(0, 255)) << 2;
      put($urandom_range(0, 3) != 0, 32'($urandom_range(0, 255)) << 2,
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) << 2 : at, at,
          k == 0, k != 0, k == 2, k == 3, 1'($urandom), 1'($urandom));
      redirect_ready = $urandom_range(0, 2) != 0;
      vecs++;
      if (w_hs !== {!m_redir, m_redir, m_redir || m_sq != 0}) begin
        errs++; $display("FAIL rnd_hs n=%0d got %b want %b", n, w_hs, {!m_redir, m_redir, m_redir || m_sq != 0});
      end
      tick();
      vecs++;
      if (w_pulse !== e_pulse) begin errs++; $display("FAIL rnd_pulse n=%0d got %b want %b", n, w_pulse, e_pulse); end
      vecs++;
      if (w_addr !== e_addr || w_snap !== e_snap || redirect_pc !== e_rpc) begin
        errs++; $display("FAIL rnd_data n=%0d addr=%h want %h rpc=%h want %h", n, w_addr, e_addr, redirect_pc, e_rpc);
      end
      vecs++;
      if (w_perf !== exp_perf()) begin errs++; $display("FAIL rnd_perf n=%0d got %h want %h", n, w_perf, exp_perf()); end
    end
  endtask

  initial begin
    test_reset();
    test_jal();
    test_branch_hit();
    test_branch_mispredict_snap();
    test_redirect_stall();
    test_call_wrap();
    test_reset_in_redirect();
    test_back_to_back();
    drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
